// File: rtl/read_pipe.sv
// read_pipe: two-stage operand-read pipe (S1 request, S2 output) with valid/ready back-pressure and flush.
// Defining READ_PIPE_BYPASS_EN forwards write-back data to operands read from S1.
module read_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 5,
  parameter int PC_W   = 31
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm_en,
  input  logic [IMM_W-1:0]  arg_imm,
  input  logic              read_a,
  input  logic              read_b,
  input  logic [REG_AW-1:0] arg_a,
  input  logic [REG_AW-1:0] arg_b,
  input  logic              pc_set,
  input  logic              pc_add,
  input  logic              pc_inc,
  input  logic [1:0]        pc_src,
  input  logic              i_alu_en,
  input  logic [4:0]        i_alu_op,
  input  logic [3:0]        i_truth_table,
  output logic              reg_a_read,
  output logic              reg_b_read,
  output logic [REG_AW-1:0] reg_a,
  output logic [REG_AW-1:0] reg_b,
  input  logic [DATA_W-1:0] reg_a_value,
  input  logic [DATA_W-1:0] reg_b_value,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              src_a_en,
  output logic              src_b_en,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic              o_pc_set,
  output logic              o_pc_add,
  output logic              o_pc_inc,
  output logic [PC_W-1:0]   pc,
  output logic              o_alu_en,
  output logic [4:0]        o_alu_op,
  output logic [3:0]        o_truth_table
);
  typedef struct packed {
    logic              imm_en;
    logic [IMM_W-1:0]  imm;
    logic              read_a;
    logic              read_b;
    logic [REG_AW-1:0] arg_a;
    logic [REG_AW-1:0] arg_b;
    logic              pc_set;
    logic              pc_add;
    logic              pc_inc;
    logic [1:0]        pc_src;
    logic              alu_en;
    logic [4:0]        alu_op;
    logic [3:0]        tt;
  } req_t;
  req_t              s1, req_in;
  logic              s1_valid, s2_free, s1_adv, accept;
  logic [DATA_W-1:0] a_val, b_val, imm_d;
  logic [PC_W-1:0]   imm_p, pc_next;
  assign req_in = {imm_en, arg_imm, read_a, read_b, arg_a, arg_b, pc_set, pc_add, pc_inc,
                   pc_src, i_alu_en, i_alu_op, i_truth_table};
  assign s2_free = !out_valid | out_ready;
  assign s1_adv = s1_valid & s2_free;
  assign in_ready = !flush & (!s1_valid | s1_adv);
  assign accept = in_valid & in_ready;
  assign reg_a = s1.arg_a;
  assign reg_b = s1.arg_b;
  assign reg_a_read = s1_valid & s1.read_a;
  assign reg_b_read = s1_valid & s1.read_b;
`ifdef READ_PIPE_BYPASS_EN
  assign a_val = (wb_en && wb_reg == s1.arg_a) ? wb_value : reg_a_value;
  assign b_val = (wb_en && wb_reg == s1.arg_b) ? wb_value : reg_b_value;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_reg, wb_value};
  assign a_val = reg_a_value;
  assign b_val = reg_b_value;
`endif
  assign imm_d = {{(DATA_W-IMM_W){s1.imm[IMM_W-1]}}, s1.imm};
  assign imm_p = {{(PC_W-IMM_W){s1.imm[IMM_W-1]}}, s1.imm};
  always_comb begin
    pc_next = s1.pc_src == 2'd0 ? imm_p :
              s1.pc_src == 2'd1 ? PC_W'(a_val) :
              s1.pc_src == 2'd2 ? PC_W'(b_val) : PC_W'({a_val, b_val});
  end
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      s1_valid <= 1'b0;
      s1 <= '0;
    end else if (flush) s1_valid <= 1'b0;
    else if (accept) begin
      s1_valid <= 1'b1;
      s1 <= req_in;
    end else if (s1_adv) s1_valid <= 1'b0;
  end
  // output data is only reloaded on advance, so it holds through stalls and after draining
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      out_valid <= 1'b0;
      src_a_en <= 1'b0;
      src_b_en <= 1'b0;
      src_a <= '0;
      src_b <= '0;
      pc <= '0;
      {o_pc_set, o_pc_add, o_pc_inc, o_alu_en, o_alu_op, o_truth_table} <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (s1_adv) begin
      out_valid <= 1'b1;
      src_a_en <= s1.read_a;
      src_b_en <= s1.read_b | s1.imm_en;
      src_a <= s1.read_a ? a_val : '0;
      src_b <= s1.imm_en ? imm_d : (s1.read_b ? b_val : '0);
      pc <= pc_next;
      {o_pc_set, o_pc_add, o_pc_inc, o_alu_en, o_alu_op, o_truth_table} <=
        {s1.pc_set, s1.pc_add, s1.pc_inc, s1.alu_en, s1.alu_op, s1.tt};
    end else if (out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_read_pipe.sv
// tb_read_pipe: directed + random stimulus for read_pipe checked against a queue-based reference model.
module tb_read_pipe;
  logic        cpu_clk = 0, cpu_rst = 1, flush = 0, in_valid = 0, imm_en = 0, read_a = 0, read_b = 0;
  logic        pc_set = 0, pc_add = 0, pc_inc = 0, i_alu_en = 0, wb_en = 0, out_ready = 0;
  logic [4:0]  arg_imm = 0, i_alu_op = 0;
  logic [3:0]  arg_a = 0, arg_b = 0, wb_reg = 0, i_truth_table = 0;
  logic [1:0]  pc_src = 0;
  logic [15:0] wb_value = 0;
  logic        in_ready, reg_a_read, reg_b_read, out_valid, src_a_en, src_b_en;
  logic        o_pc_set, o_pc_add, o_pc_inc, o_alu_en;
  logic [3:0]  reg_a, reg_b, o_truth_table;
  logic [15:0] reg_a_value, reg_b_value, src_a, src_b;
  logic [30:0] pc;
  logic [4:0]  o_alu_op;
  logic [15:0] rf [16];
  typedef struct {
    logic [15:0] sa, sb;
    logic        ae, be;
    logic [30:0] pc;
    logic [12:0] ctl;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, outs = 0, sent, outs0;
  logic acc;
  assign reg_a_value = rf[reg_a];
  assign reg_b_value = rf[reg_b];
  always #5 cpu_clk = ~cpu_clk;
  read_pipe dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm_en(imm_en), .arg_imm(arg_imm), .read_a(read_a), .read_b(read_b), .arg_a(arg_a), .arg_b(arg_b),
    .pc_set(pc_set), .pc_add(pc_add), .pc_inc(pc_inc), .pc_src(pc_src), .i_alu_en(i_alu_en),
    .i_alu_op(i_alu_op), .i_truth_table(i_truth_table), .reg_a_read(reg_a_read), .reg_b_read(reg_b_read),
    .reg_a(reg_a), .reg_b(reg_b), .reg_a_value(reg_a_value), .reg_b_value(reg_b_value), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_value(wb_value), .out_valid(out_valid), .out_ready(out_ready),
    .src_a_en(src_a_en), .src_b_en(src_b_en), .src_a(src_a), .src_b(src_b), .o_pc_set(o_pc_set),
    .o_pc_add(o_pc_add), .o_pc_inc(o_pc_inc), .pc(pc), .o_alu_en(o_alu_en), .o_alu_op(o_alu_op),
    .o_truth_table(o_truth_table)
  );
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t predict();
    exp_t e;
    int a = int'(rf[arg_a]);
    int b = int'(rf[arg_b]);
    int im = int'(arg_imm);
    longint t;
    if (im >= 16) im -= 32;
    t = (longint'(a) << 16) | longint'(b);
    e.sa = read_a ? 16'(a) : 16'd0;
    e.sb = imm_en ? 16'(im) : (read_b ? 16'(b) : 16'd0);
    e.ae = read_a;
    e.be = read_b | imm_en;
    e.pc = pc_src == 0 ? 31'(im) : pc_src == 1 ? 31'(a) : pc_src == 2 ? 31'(b) : 31'(t);
    e.ctl = {pc_set, pc_add, pc_inc, i_alu_en, i_alu_op, i_truth_table};
    return e;
  endfunction
  task automatic cyc();
    exp_t e;
    @(negedge cpu_clk);
    if (out_valid) begin
      chk("out_has_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q[0];
        chk("src_a", src_a, e.sa);
        chk("src_b", src_b, e.sb);
        chk("src_a_en", src_a_en, e.ae);
        chk("src_b_en", src_b_en, e.be);
        chk("pc", pc, e.pc);
        chk("ctl", {o_pc_set, o_pc_add, o_pc_inc, o_alu_en, o_alu_op, o_truth_table}, e.ctl);
        if (out_ready) begin
          void'(q.pop_front());
          outs++;
        end
      end
    end
    acc = in_valid && in_ready;
    if (flush) q.delete();
    else if (acc) q.push_back(predict());
    chk("occupancy", q.size() <= 2, 1);
    @(posedge cpu_clk);
    #1;
  endtask
  task automatic set_instr(logic ra, logic [3:0] aa, logic rb, logic [3:0] ab, logic ie,
                           logic [4:0] im, logic [1:0] ps);
    read_a = ra; arg_a = aa; read_b = rb; arg_b = ab; imm_en = ie; arg_imm = im; pc_src = ps;
    {pc_set, pc_add, pc_inc, i_alu_en, i_alu_op, i_truth_table} = 13'($urandom);
  endtask
  task automatic rand_instr();
    set_instr(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
              5'($urandom), 2'($urandom));
  endtask
  initial begin
    exp_t e;
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    rf[3] = 16'h1234; rf[5] = 16'h00FF; rf[7] = 16'h0001;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_src_a", src_a, 0);
    chk("rst_pc", pc, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge cpu_clk); #1;
    cpu_rst = 0;
    // basic two-operand read and latency
    out_ready = 1;
    set_instr(1, 3, 1, 5, 0, 0, 1);
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("t1_not_yet", out_valid, 0);
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_src_a", src_a, 16'h1234);
    chk("t1_src_b", src_b, 16'h00FF);
    chk("t1_ens", {src_a_en, src_b_en}, 2'b11);
    chk("t1_pc", pc, 31'h1234);
    cyc();
    // immediate beats read_b
    set_instr(0, 0, 1, 2, 1, 5'h1E, 0);
    in_valid = 1;
    cyc();
    in_valid = 0;
    cyc();
    chk("t2_src_b", src_b, 16'hFFFE);
    chk("t2_src_b_en", src_b_en, 1);
    chk("t2_pc", pc, 31'h7FFFFFFE);
    cyc();
    // stream of 4 with a 3-cycle stall
    sent = 0;
    outs0 = outs;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid = sent < 4;
      if (sent < 4) rand_instr();
      #1;
      if (c >= 2 && c <= 4) chk("t3_stall_in_ready", in_ready, 0);
      cyc();
      if (acc) sent++;
    end
    in_valid = 0;
    chk("t3_sent", sent, 4);
    chk("t3_emerged", outs - outs0, 4);
    // write-back landing while the instruction sits in S1
    out_ready = 1;
    set_instr(1, 7, 0, 0, 0, 0, 0);
    in_valid = 1;
    cyc();
    in_valid = 0;
    wb_en = 1; wb_reg = 7; wb_value = 16'hBEEF;
`ifdef READ_PIPE_BYPASS_EN
    e = q.pop_back();
    e.sa = 16'hBEEF;
    q.push_back(e);
`endif
    cyc();
    wb_en = 0;
`ifdef READ_PIPE_BYPASS_EN
    chk("t4_src_a", src_a, 16'hBEEF);
`else
    chk("t4_src_a", src_a, 16'h0001);
`endif
    cyc();
    // flush with both stages full
    out_ready = 0;
    rand_instr(); in_valid = 1;
    cyc();
    rand_instr();
    cyc();
    chk("t5_full", out_valid && !in_ready, 1);
    rand_instr();
    flush = 1;
    #1;
    chk("t5_in_ready", in_ready, 0);
    cyc();
    flush = 0; in_valid = 0;
    chk("t5_flushed", out_valid, 0);
    out_ready = 1;
    set_instr(1, 3, 1, 5, 0, 0, 3);
    in_valid = 1;
    cyc();
    chk("t5_accept", acc, 1);
    in_valid = 0;
    cyc();
    chk("t5_valid", out_valid, 1);
    chk("t5_pc", pc, 31'h123400FF);
    cyc();
    // asynchronous reset between edges
    out_ready = 0;
    rand_instr(); in_valid = 1;
    cyc();
    in_valid = 0;
    cyc();
    chk("t6_valid", out_valid, 1);
    #3 cpu_rst = 1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_data", {src_a, src_b, pc, src_a_en, src_b_en}, 0);
    chk("t6_ctl", {o_pc_set, o_pc_add, o_pc_inc, o_alu_en, o_alu_op, o_truth_table}, 0);
    q.delete();
    @(posedge cpu_clk); #2;
    cpu_rst = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_idle", out_valid, 0);
    end
    // random traffic with occasional flush
    for (int i = 0; i < 80; i++) begin
      rand_instr();
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 12) == 0;
      cyc();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) cyc();
    chk("drained", q.size(), 0);
    chk("drained_valid", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
